// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory-port arbiter and its clients.
// Widths match the 16K x 16 dual-port memory and the CPU data path.
package mem_port_arbiter_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  typedef enum logic [1:0] {
    RULE_NONE,
    RULE_LOCK,
    RULE_SINGLE,
    RULE_RR
  } grant_rule_e;

endpackage

// File: rtl/mem_port_arbiter_rr_lock_sel.sv
// Grant selection for two requesters: bounded lock hold, then single request,
// then round-robin between simultaneous requests.
module rr_lock_sel #(
  parameter int MAX_LOCK = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic [1:0] gnt
);
  import mem_port_arbiter_pkg::*;

  localparam int CNT_W = 4;

  logic             rr_last;
  logic             lock_valid;
  logic             lock_owner;
  logic [CNT_W-1:0] lock_cnt;

  grant_rule_e rule;
  logic        sel;
  logic        preempt;

  always_comb begin
    rule    = RULE_NONE;
    sel     = REQ_CPU;
    gnt     = 2'b00;
    preempt = lock_valid && req[lock_owner] && req[~lock_owner] &&
              (lock_cnt == CNT_W'(MAX_LOCK));
    if (!reset) begin
      if (preempt) begin
        rule = RULE_RR;
        sel  = ~lock_owner;
      end else if (lock_valid && req[lock_owner]) begin
        rule = RULE_LOCK;
        sel  = lock_owner;
      end else if (req == 2'b01) begin
        rule = RULE_SINGLE;
        sel  = REQ_CPU;
      end else if (req == 2'b10) begin
        rule = RULE_SINGLE;
        sel  = REQ_DMA;
      end else if (req == 2'b11) begin
        rule = RULE_RR;
        sel  = ~rr_last;
      end
      if (rule != RULE_NONE) begin
        gnt[sel] = 1'b1;
      end
    end
  end

  // A held lock only ages while the other side is actually waiting; any other
  // locked grant (including the winner of a preemption) starts a fresh hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last    <= REQ_DMA;
      lock_valid <= 1'b0;
      lock_owner <= REQ_CPU;
      lock_cnt   <= '0;
    end else begin
      if (rule != RULE_NONE) begin
        rr_last <= sel;
      end
      if (rule == RULE_LOCK && lock[sel]) begin
        if (req[~sel]) begin
          lock_cnt <= lock_cnt + CNT_W'(1);
        end
      end else if (rule != RULE_NONE && lock[sel]) begin
        lock_valid <= 1'b1;
        lock_owner <= sel;
        lock_cnt   <= '0;
      end else begin
        lock_valid <= 1'b0;
        lock_cnt   <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one port of the dual-port memory between the CPU (r0) and DMA (r1),
// steering each registered read result back to the requester that issued it.
module mem_port_arbiter #(
  parameter int ADDR_W   = mem_port_arbiter_pkg::ADDR_W,
  parameter int DATA_W   = mem_port_arbiter_pkg::DATA_W,
  parameter int MAX_LOCK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic              r0_lock,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic              r1_lock,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_out
);
  import mem_port_arbiter_pkg::*;

  logic [1:0] gnt;
  logic       rd_valid;
  logic       rd_tag;

  rr_lock_sel #(
    .MAX_LOCK(MAX_LOCK)
  ) u_sel (
    .clk  (clk),
    .reset(reset),
    .req  ({r1_req, r0_req}),
    .lock ({r1_lock, r0_lock}),
    .gnt  (gnt)
  );

  assign r0_gnt = gnt[REQ_CPU];
  assign r1_gnt = gnt[REQ_DMA];

  always_comb begin
    mem_we      = 1'b0;
    mem_address = '0;
    mem_in      = '0;
    if (gnt[REQ_CPU]) begin
      mem_we      = r0_we;
      mem_address = r0_addr;
      mem_in      = r0_wdata;
    end else if (gnt[REQ_DMA]) begin
      mem_we      = r1_we;
      mem_address = r1_addr;
      mem_in      = r1_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_tag   <= REQ_CPU;
    end else begin
      rd_valid <= (gnt[REQ_CPU] && !r0_we) || (gnt[REQ_DMA] && !r1_we);
      rd_tag   <= gnt[REQ_DMA];
    end
  end

  // Gating with reset drops a read whose data would land in the reset cycle.
  assign r0_rvalid = rd_valid && (rd_tag == REQ_CPU) && !reset;
  assign r1_rvalid = rd_valid && (rd_tag == REQ_DMA) && !reset;
  assign r0_rdata  = mem_out;
  assign r1_rdata  = mem_out;

endmodule
